// File: rtl/instruction_memory_loader.sv
// Instruction memory for the NanoRisc core: clears itself to NOP after reset,
// loads a program byte stream over valid/ready, then serves fetches combinationally.
module instruction_memory_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  NOP_WORD = 8'h00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] fetch_address,
  output logic [7:0]        fetch_instruction,
  output logic              cpu_run,
  output logic [ADDR_W:0]   loaded_count,
  output logic [7:0]        load_checksum
);

  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic [ADDR_W-1:0]   wr_addr;

  // Checksum is a plain modulo-256 sum; the carry out is intentionally dropped.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign accept  = load_valid & load_ready;
  assign wr_addr = loaded_count[ADDR_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= CLEAR;
      clr_ptr       <= '0;
      load_ready    <= 1'b0;
      cpu_run       <= 1'b0;
      loaded_count  <= '0;
      load_checksum <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + PTR_ONE;
          if (clr_ptr == '1) begin
            state      <= LOAD;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            loaded_count  <= loaded_count + CNT_ONE;
            load_checksum <= wrap_add(load_checksum, load_data);
            // Top address filled: no room for a further byte, release the core.
            if (load_last || (wr_addr == '1)) begin
              state      <= RUN;
              load_ready <= 1'b0;
              cpu_run    <= 1'b1;
            end
          end
        end
        RUN: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the CLEAR sweep is what initialises it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= NOP_WORD;
      end else if (accept) begin
        mem[wr_addr] <= load_data;
      end
    end
  end

  always_comb begin
    fetch_instruction = NOP_WORD;
    if (cpu_run) fetch_instruction = mem[fetch_address];
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader: clear timing, loading, overflow,
// mid-load reset and RUN-state behaviour.
module tb_instruction_memory_loader;

  logic       clock;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] fetch_address;
  logic [7:0] fetch_instruction;
  logic       cpu_run;
  logic [8:0] loaded_count;
  logic [7:0] load_checksum;

  int checks = 0;
  int passes = 0;

  instruction_memory_loader #(.ADDR_W(8), .NOP_WORD(8'h00)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .fetch_address(fetch_address),
    .fetch_instruction(fetch_instruction), .cpu_run(cpu_run),
    .loaded_count(loaded_count), .load_checksum(load_checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (!load_ready && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (load_ready !== 1'b1) $display("FAIL wait_clear: load_ready=%b after %0d cycles, need 1", load_ready, n);
    else passes++;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fetch_address = 8'h05;
    tick();
    tick();
    checks++; if (load_ready !== 1'b0) $display("FAIL reset_ready: got %b need 0", load_ready); else passes++;
    checks++; if (cpu_run !== 1'b0) $display("FAIL reset_run: got %b need 0", cpu_run); else passes++;
    checks++; if (loaded_count !== 9'd0) $display("FAIL reset_count: got %0d need 0", loaded_count); else passes++;
    checks++; if (load_checksum !== 8'h00) $display("FAIL reset_sum: got %h need 00", load_checksum); else passes++;
    checks++; if (fetch_instruction !== 8'h00) $display("FAIL reset_fetch: got %h need 00", fetch_instruction); else passes++;
  endtask

  task automatic test_clear_idle();
    int n;
    int bad;
    reset = 1'b0;
    n = 0;
    while (!load_ready && n < 400) begin
      tick();
      n++;
    end
    checks++; if (n !== 256) $display("FAIL clear_len: load_ready rose after %0d cycles, need 256", n); else passes++;
    for (int i = 0; i < 44; i++) tick();
    checks++; if (load_ready !== 1'b1) $display("FAIL idle_ready: got %b need 1", load_ready); else passes++;
    checks++; if (cpu_run !== 1'b0) $display("FAIL idle_run: got %b need 0", cpu_run); else passes++;
    checks++; if (loaded_count !== 9'd0) $display("FAIL idle_count: got %0d need 0", loaded_count); else passes++;
    send(8'h00, 1'b1);
    bad = 0;
    for (int a = 1; a < 256; a++) begin
      fetch_address = a[7:0];
      #1;
      if (fetch_instruction !== 8'h00) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL clear_fill: %0d addresses not 00, need 0", bad); else passes++;
  endtask

  task automatic test_basic_load();
    logic [7:0] exp [4];
    exp = '{8'h21, 8'h43, 8'h65, 8'h00};
    do_reset();
    wait_clear();
    load_valid = 1'b1; load_last = 1'b0;
    load_data = 8'h21; tick();
    load_data = 8'h43; tick();
    checks++; if (cpu_run !== 1'b0) $display("FAIL basic_early_run: got %b need 0", cpu_run); else passes++;
    load_data = 8'h65; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (cpu_run !== 1'b1) $display("FAIL basic_run: got %b need 1", cpu_run); else passes++;
    checks++; if (load_ready !== 1'b0) $display("FAIL basic_ready: got %b need 0", load_ready); else passes++;
    checks++; if (loaded_count !== 9'd3) $display("FAIL basic_count: got %0d need 3", loaded_count); else passes++;
    checks++; if (load_checksum !== 8'hC9) $display("FAIL basic_sum: got %h need c9", load_checksum); else passes++;
    for (int a = 0; a < 4; a++) begin
      fetch_address = a[7:0];
      #1;
      checks++;
      if (fetch_instruction !== exp[a]) $display("FAIL basic_fetch%0d: got %h need %h", a, fetch_instruction, exp[a]);
      else passes++;
    end
  endtask

  task automatic test_gapped();
    logic [7:0] exp [8];
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10, 8'h00};
    do_reset();
    wait_clear();
    for (int i = 0; i < 6; i++) begin
      send(8'(i + 1), 1'b0);
      load_data = 8'hEE; load_last = 1'b1;
      tick();
      load_last = 1'b0;
    end
    checks++; if (cpu_run !== 1'b0) $display("FAIL gap_run_early: got %b need 0", cpu_run); else passes++;
    checks++; if (loaded_count !== 9'd6) $display("FAIL gap_count_mid: got %0d need 6", loaded_count); else passes++;
    send(8'h10, 1'b1);
    checks++; if (cpu_run !== 1'b1) $display("FAIL gap_run: got %b need 1", cpu_run); else passes++;
    checks++; if (loaded_count !== 9'd7) $display("FAIL gap_count: got %0d need 7", loaded_count); else passes++;
    checks++; if (load_checksum !== 8'h25) $display("FAIL gap_sum: got %h need 25", load_checksum); else passes++;
    for (int a = 0; a < 8; a++) begin
      fetch_address = a[7:0];
      #1;
      checks++;
      if (fetch_instruction !== exp[a]) $display("FAIL gap_fetch%0d: got %h need %h", a, fetch_instruction, exp[a]);
      else passes++;
    end
  endtask

  task automatic test_overflow();
    int seen_ready;
    do_reset();
    wait_clear();
    seen_ready = 0;
    load_last = 1'b0;
    for (int i = 0; i < 300; i++) begin
      load_valid = 1'b1;
      load_data  = i[7:0];
      if (load_ready) seen_ready++;
      tick();
    end
    load_valid = 1'b0;
    checks++; if (seen_ready !== 256) $display("FAIL ovf_ready_beats: got %0d need 256", seen_ready); else passes++;
    checks++; if (loaded_count !== 9'd256) $display("FAIL ovf_count: got %0d need 256", loaded_count); else passes++;
    checks++; if (load_checksum !== 8'h80) $display("FAIL ovf_sum: got %h need 80", load_checksum); else passes++;
    checks++; if (cpu_run !== 1'b1) $display("FAIL ovf_run: got %b need 1", cpu_run); else passes++;
    fetch_address = 8'hFF; #1;
    checks++; if (fetch_instruction !== 8'hFF) $display("FAIL ovf_fetch255: got %h need ff", fetch_instruction); else passes++;
    fetch_address = 8'h00; #1;
    checks++; if (fetch_instruction !== 8'h00) $display("FAIL ovf_fetch0: got %h need 00", fetch_instruction); else passes++;
    fetch_address = 8'h7B; #1;
    checks++; if (fetch_instruction !== 8'h7B) $display("FAIL ovf_fetch7b: got %h need 7b", fetch_instruction); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wait_clear();
    for (int i = 0; i < 5; i++) send(8'(8'h11 + i), 1'b0);
    checks++; if (loaded_count !== 9'd5) $display("FAIL mid_count_pre: got %0d need 5", loaded_count); else passes++;
    reset = 1'b1; load_valid = 1'b1; load_data = 8'h16;
    tick();
    reset = 1'b0; load_valid = 1'b0;
    checks++; if (loaded_count !== 9'd0) $display("FAIL mid_count_rst: got %0d need 0", loaded_count); else passes++;
    checks++; if (load_ready !== 1'b0) $display("FAIL mid_ready_rst: got %b need 0", load_ready); else passes++;
    checks++; if (load_checksum !== 8'h00) $display("FAIL mid_sum_rst: got %h need 00", load_checksum); else passes++;
    wait_clear();
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    checks++; if (loaded_count !== 9'd2) $display("FAIL mid_count: got %0d need 2", loaded_count); else passes++;
    checks++; if (load_checksum !== 8'h00) $display("FAIL mid_sum: got %h need 00", load_checksum); else passes++;
    checks++; if (cpu_run !== 1'b1) $display("FAIL mid_run: got %b need 1", cpu_run); else passes++;
    for (int a = 2; a < 5; a++) begin
      fetch_address = a[7:0];
      #1;
      checks++;
      if (fetch_instruction !== 8'h00) $display("FAIL mid_fetch%0d: got %h need 00", a, fetch_instruction);
      else passes++;
    end
  endtask

  task automatic test_run_ignore();
    load_valid = 1'b1; load_data = 8'hAA; load_last = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (loaded_count !== 9'd2) $display("FAIL run_count: got %0d need 2", loaded_count); else passes++;
    checks++; if (load_checksum !== 8'h00) $display("FAIL run_sum: got %h need 00", load_checksum); else passes++;
    checks++; if (load_ready !== 1'b0) $display("FAIL run_ready: got %b need 0", load_ready); else passes++;
    fetch_address = 8'h00; #1;
    checks++; if (fetch_instruction !== 8'hFF) $display("FAIL run_fetch0: got %h need ff", fetch_instruction); else passes++;
    fetch_address = 8'h01; #1;
    checks++; if (fetch_instruction !== 8'h01) $display("FAIL run_fetch1: got %h need 01", fetch_instruction); else passes++;
    fetch_address = 8'h02; #1;
    checks++; if (fetch_instruction !== 8'h00) $display("FAIL run_fetch2: got %h need 00", fetch_instruction); else passes++;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0; fetch_address = 8'h00;
    test_reset();
    test_clear_idle();
    test_basic_load();
    test_gapped();
    test_overflow();
    test_reset_mid();
    test_run_ignore();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
